// File: rtl/filtro_store_buffer.sv
// Store formatting unit: aligns REG[rt] into byte lanes, flags misaligned or
// illegal stores, and posts good stores into a small FIFO that drains to memory.
module filtro_store_buffer #(
    parameter int NBITS  = 32,
    parameter int TNBITS = 2,
    parameter int ABITS  = 32,
    parameter int DEPTH  = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [ABITS-1:0]            i_addr,
    input  logic [NBITS-1:0]            i_dato_rt,
    input  logic [TNBITS-1:0]           i_selector,
    input  logic                        i_flush,
    output logic                        o_mem_valid,
    input  logic                        i_mem_ready,
    output logic [ABITS-1:0]            o_mem_addr,
    output logic [NBITS-1:0]            o_mem_data,
    output logic [NBITS/8-1:0]          o_mem_be,
    output logic                        o_misaligned,
    output logic                        o_illegal,
    output logic [ABITS-1:0]            o_bad_addr,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count
);
    localparam int NB  = NBITS / 8;
    localparam int OFS = $clog2(NB);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    localparam logic [TNBITS-1:0] SEL_WORD = TNBITS'(0);
    localparam logic [TNBITS-1:0] SEL_SB   = TNBITS'(1);
    localparam logic [TNBITS-1:0] SEL_SH   = TNBITS'(2);

    localparam logic [NB-1:0] BE_B = NB'(1);
    localparam logic [NB-1:0] BE_H = NB'(3);
    localparam logic [NB-1:0] BE_W = NB'(15);

    logic [ABITS-1:0] mem_addr_q [DEPTH];
    logic [NBITS-1:0] mem_data_q [DEPTH];
    logic [NB-1:0]    mem_be_q   [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    logic [OFS-1:0]   k;
    logic [NBITS-1:0] fmt_data;
    logic [NB-1:0]    fmt_be;
    logic             misal, illegal;
    logic             accept, push, pop;

    assign k = i_addr[OFS-1:0];

    always_comb begin
        fmt_data = '0;
        fmt_be   = '0;
        misal    = 1'b0;
        illegal  = 1'b0;
        case (i_selector)
            SEL_SB: begin
                fmt_data = {NB{i_dato_rt[7:0]}};
                fmt_be   = BE_B << k;
            end
            SEL_SH: begin
                fmt_data = {(NB/2){i_dato_rt[15:0]}};
                fmt_be   = BE_H << k;
                misal    = k[0];
            end
            SEL_WORD: begin
                fmt_data = {(NB/4){i_dato_rt[31:0]}};
                fmt_be   = BE_W << k;
                misal    = |k[1:0];
            end
            default: illegal = 1'b1;
        endcase
    end

    // Upstream: a store transfers on a rising edge where i_valid && o_ready
    // && !i_flush. Downstream: the head transfers where o_mem_valid &&
    // i_mem_ready && !i_flush. o_ready depends only on occupancy.
    assign o_ready     = (count != CW'(DEPTH));
    assign o_empty     = (count == '0);
    assign o_mem_valid = !o_empty;
    assign o_count     = count;

    assign accept = i_valid && o_ready && !i_flush;
    assign push   = accept && !misal && !illegal;
    assign pop    = o_mem_valid && i_mem_ready && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entries are cleared on reset so the head outputs read zero afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
                mem_be_q[i]   <= '0;
            end
        end else if (push) begin
            mem_addr_q[wr_ptr] <= {i_addr[ABITS-1:OFS], {OFS{1'b0}}};
            mem_data_q[wr_ptr] <= fmt_data;
            mem_be_q[wr_ptr]   <= fmt_be;
        end
    end

    assign o_mem_addr = mem_addr_q[rd_ptr];
    assign o_mem_data = mem_data_q[rd_ptr];
    assign o_mem_be   = mem_be_q[rd_ptr];

    // Illegal selector wins over misalignment; neither fires during flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_misaligned <= 1'b0;
            o_illegal    <= 1'b0;
            o_bad_addr   <= '0;
        end else begin
            o_illegal    <= accept && illegal;
            o_misaligned <= accept && !illegal && misal;
            if (accept && (illegal || misal)) o_bad_addr <= i_addr;
        end
    end

endmodule

// File: tb/tb_filtro_store_buffer.sv
// Directed bench for filtro_store_buffer at NBITS=32, DEPTH=4.
module tb_filtro_store_buffer;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_addr;
    logic [31:0] i_dato_rt;
    logic [1:0]  i_selector;
    logic        i_flush;
    logic        o_mem_valid;
    logic        i_mem_ready;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic [3:0]  o_mem_be;
    logic        o_misaligned;
    logic        o_illegal;
    logic [31:0] o_bad_addr;
    logic        o_empty;
    logic [2:0]  o_count;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [1:0] SW = 2'b00, SB = 2'b01, SH = 2'b10, SX = 2'b11;

    filtro_store_buffer #(.NBITS(32), .TNBITS(2), .ABITS(32), .DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_addr(i_addr), .i_dato_rt(i_dato_rt), .i_selector(i_selector),
        .i_flush(i_flush), .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
        .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_be(o_mem_be),
        .o_misaligned(o_misaligned), .o_illegal(o_illegal), .o_bad_addr(o_bad_addr),
        .o_empty(o_empty), .o_count(o_count)
    );

    // Clock / reset
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Driver: present one store for one edge, then drop i_valid.
    task automatic drive_store(input logic [31:0] a, input logic [31:0] rt, input logic [1:0] sel);
        i_addr = a; i_dato_rt = rt; i_selector = sel; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        i_mem_ready = 1'b1;
        while (!o_empty && n < 20) begin
            step();
            n++;
        end
        i_mem_ready = 1'b0;
        n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL drain_timeout got empty=%b want 1", o_empty); end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_valid = 1'b0; i_addr = '0; i_dato_rt = '0;
        i_selector = '0; i_flush = 1'b0; i_mem_ready = 1'b0;
        #12;
        n_cmp++; if (o_count !== 3'd0)  begin n_fail++; $display("FAIL rst_count got %0d want 0", o_count); end
        n_cmp++; if (o_empty !== 1'b1)  begin n_fail++; $display("FAIL rst_empty got %b want 1", o_empty); end
        n_cmp++; if (o_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_ready got %b want 1", o_ready); end
        n_cmp++; if (o_mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid got %b want 0", o_mem_valid); end
        n_cmp++; if ({o_mem_addr, o_mem_data, o_mem_be} !== 68'h0) begin n_fail++; $display("FAIL rst_mem got %h/%h/%b want 0", o_mem_addr, o_mem_data, o_mem_be); end
        n_cmp++; if ({o_misaligned, o_illegal} !== 2'b00) begin n_fail++; $display("FAIL rst_faults got %b%b want 00", o_misaligned, o_illegal); end
        n_cmp++; if (o_bad_addr !== 32'h0) begin n_fail++; $display("FAIL rst_bad got %h want 0", o_bad_addr); end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_sb();
        drive_store(32'h1003, 32'hAABBCCDD, SB);
        n_cmp++; if (o_mem_addr !== 32'h1000) begin n_fail++; $display("FAIL sb_addr got %h want 1000", o_mem_addr); end
        n_cmp++; if (o_mem_data !== 32'hDDDDDDDD) begin n_fail++; $display("FAIL sb_data got %h want dddddddd", o_mem_data); end
        n_cmp++; if (o_mem_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be got %b want 1000", o_mem_be); end
        n_cmp++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL sb_count got %0d want 1", o_count); end
        n_cmp++; if (o_mem_valid !== 1'b1) begin n_fail++; $display("FAIL sb_mvalid got %b want 1", o_mem_valid); end
        drain();
    endtask

    task automatic test_sh();
        drive_store(32'h2002, 32'h00001234, SH);
        n_cmp++; if (o_mem_data !== 32'h12341234) begin n_fail++; $display("FAIL sh_data got %h want 12341234", o_mem_data); end
        n_cmp++; if (o_mem_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be got %b want 1100", o_mem_be); end
        n_cmp++; if (o_mem_addr !== 32'h2000) begin n_fail++; $display("FAIL sh_addr got %h want 2000", o_mem_addr); end
        drive_store(32'h2001, 32'h00001234, SH);
        n_cmp++; if ({o_misaligned, o_illegal} !== 2'b10) begin n_fail++; $display("FAIL sh_mis_pulse got %b%b want 10", o_misaligned, o_illegal); end
        n_cmp++; if (o_bad_addr !== 32'h2001) begin n_fail++; $display("FAIL sh_bad got %h want 2001", o_bad_addr); end
        n_cmp++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL sh_mis_count got %0d want 1", o_count); end
        step();
        n_cmp++; if (o_misaligned !== 1'b0) begin n_fail++; $display("FAIL sh_mis_clear got %b want 0", o_misaligned); end
        drain();
    endtask

    task automatic test_word();
        drive_store(32'h3004, 32'hCAFEF00D, SW);
        n_cmp++; if (o_mem_be !== 4'hF) begin n_fail++; $display("FAIL w_be got %h want f", o_mem_be); end
        n_cmp++; if (o_mem_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL w_data got %h want cafef00d", o_mem_data); end
        n_cmp++; if (o_mem_addr !== 32'h3004) begin n_fail++; $display("FAIL w_addr got %h want 3004", o_mem_addr); end
        drive_store(32'h3008, 32'h11111111, SX);
        n_cmp++; if ({o_misaligned, o_illegal} !== 2'b01) begin n_fail++; $display("FAIL ill_pulse got %b%b want 01", o_misaligned, o_illegal); end
        n_cmp++; if (o_bad_addr !== 32'h3008) begin n_fail++; $display("FAIL ill_bad got %h want 3008", o_bad_addr); end
        n_cmp++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL ill_count got %0d want 1", o_count); end
        drive_store(32'h3006, 32'h22222222, SW);
        n_cmp++; if ({o_misaligned, o_illegal} !== 2'b10) begin n_fail++; $display("FAIL wmis_pulse got %b%b want 10", o_misaligned, o_illegal); end
        n_cmp++; if (o_bad_addr !== 32'h3006) begin n_fail++; $display("FAIL wmis_bad got %h want 3006", o_bad_addr); end
        drain();
    endtask

    task automatic test_full();
        logic [31:0] ea [4];
        logic [31:0] ed [4];
        logic [3:0]  eb [4];
        ea = '{32'h4000, 32'h4000, 32'h4000, 32'h4008};
        ed = '{32'h11111111, 32'h22222222, 32'h33443344, 32'h55667788};
        eb = '{4'b0001, 4'b0010, 4'b1100, 4'b1111};
        drive_store(32'h4000, 32'h00000011, SB);
        drive_store(32'h4001, 32'h00000022, SB);
        drive_store(32'h4002, 32'h00003344, SH);
        drive_store(32'h4008, 32'h55667788, SW);
        n_cmp++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", o_count); end
        n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", o_ready); end
        i_addr = 32'h4100; i_dato_rt = 32'h99; i_selector = SB; i_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if ({o_mem_addr, o_mem_data, o_mem_be} !== {ea[0], ed[0], eb[0]}) begin n_fail++; $display("FAIL hold%0d got %h/%h/%b want %h/%h/%b", c, o_mem_addr, o_mem_data, o_mem_be, ea[0], ed[0], eb[0]); end
            n_cmp++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL hold%0d_count got %0d want 4", c, o_count); end
        end
        i_valid = 1'b0;
        i_mem_ready = 1'b1;
        #1;
        n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL nobypass_ready got %b want 0", o_ready); end
        for (int e = 1; e < 4; e++) begin
            step();
            n_cmp++; if ({o_mem_addr, o_mem_data, o_mem_be} !== {ea[e], ed[e], eb[e]}) begin n_fail++; $display("FAIL order%0d got %h/%h/%b want %h/%h/%b", e, o_mem_addr, o_mem_data, o_mem_be, ea[e], ed[e], eb[e]); end
            n_cmp++; if (o_count !== 3'(4 - e)) begin n_fail++; $display("FAIL order%0d_count got %0d want %0d", e, o_count, 4 - e); end
            n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL order%0d_ready got %b want 1", e, o_ready); end
        end
        step();
        n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL full_drained got %b want 1", o_empty); end
        i_mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive_store(32'h5000, 32'h000000AA, SB);
        drive_store(32'h5001, 32'h000000BB, SB);
        n_cmp++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL pp_pre got %0d want 2", o_count); end
        i_addr = 32'h5002; i_dato_rt = 32'hCC; i_selector = SB; i_valid = 1'b1; i_mem_ready = 1'b1;
        step();
        i_valid = 1'b0; i_mem_ready = 1'b0;
        n_cmp++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL pp_count got %0d want 2", o_count); end
        n_cmp++; if ({o_mem_data, o_mem_be} !== {32'hBBBBBBBB, 4'b0010}) begin n_fail++; $display("FAIL pp_head got %h/%b want bbbbbbbb/0010", o_mem_data, o_mem_be); end
        drain();
    endtask

    task automatic test_flush();
        drive_store(32'h6000, 32'h00000077, SB);
        n_cmp++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL fl_pre got %0d want 1", o_count); end
        i_addr = 32'h6001; i_dato_rt = 32'h0; i_selector = SH; i_valid = 1'b1; i_flush = 1'b1;
        step();
        i_valid = 1'b0; i_flush = 1'b0;
        n_cmp++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL fl_count got %0d want 0", o_count); end
        n_cmp++; if ({o_empty, o_mem_valid, o_ready} !== 3'b101) begin n_fail++; $display("FAIL fl_flags got %b%b%b want 101", o_empty, o_mem_valid, o_ready); end
        n_cmp++; if ({o_misaligned, o_illegal} !== 2'b00) begin n_fail++; $display("FAIL fl_fault got %b%b want 00", o_misaligned, o_illegal); end
        n_cmp++; if (o_bad_addr !== 32'h3006) begin n_fail++; $display("FAIL fl_bad got %h want 3006", o_bad_addr); end
    endtask

    task automatic test_async_reset();
        drive_store(32'h7000, 32'h00000099, SB);
        drive_store(32'h7001, 32'h00000088, SB);
        i_addr = 32'h7002; i_dato_rt = 32'h77; i_selector = SB; i_valid = 1'b1;
        #3;
        i_rst_n = 1'b0;
        #1;
        n_cmp++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL ar_count got %0d want 0", o_count); end
        n_cmp++; if ({o_empty, o_mem_valid, o_ready} !== 3'b101) begin n_fail++; $display("FAIL ar_flags got %b%b%b want 101", o_empty, o_mem_valid, o_ready); end
        n_cmp++; if ({o_mem_addr, o_mem_data, o_mem_be} !== 68'h0) begin n_fail++; $display("FAIL ar_mem got %h/%h/%b want 0", o_mem_addr, o_mem_data, o_mem_be); end
        n_cmp++; if (o_bad_addr !== 32'h0) begin n_fail++; $display("FAIL ar_bad got %h want 0", o_bad_addr); end
        i_valid = 1'b0;
        step();
        i_rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_word();
        test_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/filtro_store_buffer.md
# filtro_store_buffer

Parametrised store-formatting unit with a posted write buffer, between the MEM-stage store path and data memory. Per accepted store it:
- turns REG[rt], the byte address and the store-size selector into a lane-aligned write word plus byte enables;
- rejects misaligned or illegal stores with a one-cycle fault pulse;
- queues good stores in a DEPTH-entry FIFO drained to memory through a valid/ready handshake.

## Interface
- NBITS, 32, data-path width; legal values 32 or 64; NB = NBITS/8 byte lanes, OFS = log2(NB) offset bits
- TNBITS, 2, selector width
- ABITS, 32, byte-address width
- DEPTH, 4, write-buffer entries; power of two, ≥2
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  asynchronous active-low reset, one clock
- i_valid  in  1  store request present
- o_ready  out  1  buffer can accept; equals not-full
- i_addr  in  ABITS  byte address (base+offset)
- i_dato_rt  in  NBITS  REG[rt]
- i_selector  in  TNBITS  00 word (32-bit), 01 SB, 10 SH, 11 illegal
- i_flush  in  1  discard all buffered stores
- o_mem_valid  out  1  head entry valid
- i_mem_ready  in  1  memory accepts head entry
- o_mem_addr  out  ABITS  head address, low OFS bits forced 0
- o_mem_data  out  NBITS  head data, lane-replicated
- o_mem_be  out  NB  head byte enables
- o_misaligned  out  1  one-cycle fault pulse
- o_illegal  out  1  one-cycle pulse, selector 11
- o_bad_addr  out  ABITS  address of last faulted request, held until next fault
- o_empty  out  1  buffer empty
- o_count  out  log2(DEPTH)+1  entries held

## Operation
- Handshake: request accepted when i_valid && o_ready && !i_flush.
- Formatting, with k = i_addr[OFS-1:0]:
  - SB: data = rt[7:0] replicated NB times; be = 1<<k.
  - SH: data = rt[15:0] replicated NB/2 times; be = 2'b11<<k. Requires k[0]=0.
  - Word: data = rt[31:0] replicated NB/4 times; be = 4'hF<<k. Requires k[1:0]=0.
- Faults are evaluated only on an accepted request:
  - Misaligned (alignment rule above violated): not enqueued; o_misaligned=1 next cycle; o_bad_addr<=i_addr.
  - Selector 11: not enqueued; o_illegal=1 next cycle; o_bad_addr<=i_addr.
  - The two pulses are never set together; selector 11 takes precedence.
- FIFO:
  - Push on a good accepted request; pop when o_mem_valid && i_mem_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- Flush:
  - i_flush=1 clears count and pointers at the edge, overriding push and pop that cycle.
  - Faults are not raised during flush.
  - Memory may have sampled the head that cycle; the upstream flusher owns that hazard.
- State per entry: addr, data, be. The block has no FSM beyond FIFO occupancy: EMPTY (count 0), PARTIAL, FULL (count DEPTH).

## Timing
- Reset (async assert, sync release): count=0, pointers=0, o_mem_valid=0, o_empty=1, o_ready=1, o_misaligned=0, o_illegal=0, o_bad_addr=0, o_mem_addr=0, o_mem_data=0, o_mem_be=0.
- Reset mid-operation drops all entries immediately.
- Latency: a store accepted at edge N appears on o_mem_* after edge N, if the buffer was empty.
- o_mem_* come from registered storage, with no combinational path from i_* inputs.
- Hold rule: while o_mem_valid=1 and i_mem_ready=0, o_mem_* are stable.
- o_ready depends only on count. When full, there is no same-cycle bypass on pop; o_ready rises the cycle after a pop.
- Throughput: one store per cycle sustained when i_mem_ready=1.

## Test plan
- Reset, then NBITS=32, SB addr 0x1003, rt=0xAABBCCDD → next cycle o_mem_addr=0x1000, data=0xDDDDDDDD, be=4'b1000, count=1.
- SH addr 0x2002, rt=0x1234 → data=0x12341234, be=4'b1100. SH addr 0x2001 → o_misaligned pulse, o_bad_addr=0x2001, count unchanged.
- Word addr 0x3004 rt=0xCAFEF00D → be=4'hF. Selector 11 → o_illegal pulse only.
- i_mem_ready=0, push DEPTH stores → o_ready=0 at count=4. Hold 3 cycles → o_mem_* stable. Release → FIFO order preserved, o_ready rises one cycle after first pop.
- Simultaneous push+pop at count 2 → count stays 2. Flush with push the same cycle → count=0, o_empty=1, no fault.
- Assert i_rst_n=0 mid-burst without a clock edge → outputs go to reset values immediately.
